// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer: packet framing,
// FSM state encoding and error codes reported on LastErr.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PKT_LEN   = 5;

  // One state per packet byte plus the write phase.
  typedef enum logic [$clog2(PKT_LEN + 1)-1:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DHI   = 3'd2,
    ST_DLO   = 3'd3,
    ST_CHK   = 3'd4,
    ST_WRITE = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_CHECKSUM     = 3'd1,
    ERR_FRAMING      = 3'd2,
    ERR_BYTE_TIMEOUT = 3'd3,
    ERR_OVERRUN      = 3'd4,
    ERR_WR_TIMEOUT   = 3'd5
  } err_code_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / register-write-out bundle of the command sequencer, plus a debug
// view of the FSM state.
interface uart_cmd_ctrl_if;
  import uart_cmd_pkg::*;

  // RxValid is a one-cycle strobe with no back-pressure: RxData/RxFrameErr are
  // only meaningful while it is high. WrReq is a request held high with
  // WrAddr/WrData frozen until the cycle WrAck is sampled high; WrAck seen
  // while WrReq is low has no effect.
  logic        RxValid;
  logic [7:0]  RxData;
  logic        RxFrameErr;
  logic        WrReq;
  logic [7:0]  WrAddr;
  logic [15:0] WrData;
  logic        WrAck;
  logic        Busy;
  logic [15:0] PktCount;
  logic [7:0]  ErrCount;
  logic [2:0]  LastErr;
  state_e      DbgState;

  modport master (
    input  RxValid, RxData, RxFrameErr, WrAck,
    output WrReq, WrAddr, WrData, Busy, PktCount, ErrCount, LastErr, DbgState
  );

  modport slave (
    output RxValid, RxData, RxFrameErr, WrAck,
    input  WrReq, WrAddr, WrData, Busy, PktCount, ErrCount, LastErr, DbgState
  );

endinterface

// File: rtl/uart_cmd_timer.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and pulses
// expire_o for one cycle when TIMEOUT_CYCLES-1 is reached.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int              W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0]    LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == LIMIT);

  // Restarting on expiry keeps the pulse one cycle wide even if clr_i is late.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (clr_i || expire_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames received UART bytes into A5/ADDR/DHI/DLO/CHK packets, issues one
// register write per valid packet and counts/reports aborted packets.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_RATE       = 100000000,
  parameter int TIMEOUT_CYCLES = CLK_RATE / 1000
) (
  input  logic              Clk,
  input  logic              Reset,
  uart_cmd_ctrl_if.master   bus
);

  state_e      state_q;
  logic        busy_q;
  logic [7:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [7:0]  dlo_q;
  logic        wr_req_q;
  logic [7:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic [15:0] pkt_cnt_q;
  logic [7:0]  err_cnt_q;
  err_code_e   last_err_q;

  logic        tmr_clr_d;
  logic        tmr_en_d;
  logic        tmr_expire;
  logic [7:0]  chk_exp_d;

  // Every transition is caused by a byte, an expiry or a completed write, so
  // clearing on those three covers "cleared on state entry" as well.
  assign tmr_clr_d = bus.RxValid || tmr_expire || (wr_req_q && bus.WrAck);
  assign tmr_en_d  = (state_q != ST_IDLE);
  assign chk_exp_d = addr_q ^ dhi_q ^ dlo_q;

  uart_cmd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr_i    (tmr_clr_d),
    .en_i     (tmr_en_d),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      last_err_q <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.RxValid) begin
            if (bus.RxFrameErr) begin
              err_cnt_q  <= sat_inc8(err_cnt_q);
              last_err_q <= ERR_FRAMING;
            end else if (bus.RxData == SYNC_BYTE) begin
              state_q <= ST_ADDR;
              busy_q  <= 1'b1;
            end
          end
        end

        ST_ADDR, ST_DHI, ST_DLO, ST_CHK: begin
          if (bus.RxValid) begin
            if (bus.RxFrameErr) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              err_cnt_q  <= sat_inc8(err_cnt_q);
              last_err_q <= ERR_FRAMING;
            end else begin
              case (state_q)
                ST_ADDR: begin
                  addr_q  <= bus.RxData;
                  state_q <= ST_DHI;
                end
                ST_DHI: begin
                  dhi_q   <= bus.RxData;
                  state_q <= ST_DLO;
                end
                ST_DLO: begin
                  dlo_q   <= bus.RxData;
                  state_q <= ST_CHK;
                end
                default: begin
                  if (bus.RxData == chk_exp_d) begin
                    state_q   <= ST_WRITE;
                    wr_req_q  <= 1'b1;
                    wr_addr_q <= addr_q;
                    wr_data_q <= {dhi_q, dlo_q};
                  end else begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    err_cnt_q  <= sat_inc8(err_cnt_q);
                    last_err_q <= ERR_CHECKSUM;
                  end
                end
              endcase
            end
          end else if (tmr_expire) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            err_cnt_q  <= sat_inc8(err_cnt_q);
            last_err_q <= ERR_BYTE_TIMEOUT;
          end
        end

        ST_WRITE: begin
          // A byte here is lost but never cancels the pending write.
          if (bus.RxValid) begin
            err_cnt_q  <= sat_inc8(err_cnt_q);
            last_err_q <= ERR_OVERRUN;
          end
          if (bus.WrAck) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            wr_req_q  <= 1'b0;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
          end else if (tmr_expire && !bus.RxValid) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            err_cnt_q  <= sat_inc8(err_cnt_q);
            last_err_q <= ERR_WR_TIMEOUT;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.WrReq    = wr_req_q;
  assign bus.WrAddr   = wr_addr_q;
  assign bus.WrData   = wr_data_q;
  assign bus.Busy     = busy_q;
  assign bus.PktCount = pkt_cnt_q;
  assign bus.ErrCount = err_cnt_q;
  assign bus.LastErr  = last_err_q;
  assign bus.DbgState = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: packet-level reference model checked every
// cycle, a write scoreboard, and literal expectations at key points.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int T = 20;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(
    .CLK_RATE       (20000),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit compare_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_collecting;
  bit          m_writing;
  bit          m_req;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_pkt;
  logic [7:0]  m_err;
  logic [2:0]  m_last;
  int          m_silent;
  logic [7:0]  m_bytes[$];
  logic [23:0] exp_q[$];

  bit          s_rx;
  bit          s_ferr;
  logic [7:0]  s_data;
  bit          s_ack;
  bit          s_moved;

  task automatic m_log(input logic [2:0] code);
    if (m_err < 8'hFF) m_err = m_err + 8'd1;
    m_last = code;
  endtask

  task automatic m_reset();
    m_collecting = 1'b0;
    m_writing    = 1'b0;
    m_req        = 1'b0;
    m_addr       = '0;
    m_data       = '0;
    m_pkt        = '0;
    m_err        = '0;
    m_last       = '0;
    m_silent     = 0;
    m_bytes.delete();
  endtask

  task automatic m_step();
    s_rx    = bus.RxValid;
    s_ferr  = bus.RxFrameErr;
    s_data  = bus.RxData;
    s_ack   = bus.WrAck;
    s_moved = 1'b0;
    if (m_writing) begin
      if (s_rx) m_log(3'd4);
      if (s_ack) begin
        m_writing = 1'b0;
        m_req     = 1'b0;
        m_pkt     = m_pkt + 16'd1;
        s_moved   = 1'b1;
      end else if (!s_rx && m_silent == T - 1) begin
        m_writing = 1'b0;
        m_req     = 1'b0;
        m_log(3'd5);
        s_moved   = 1'b1;
      end
    end else if (m_collecting) begin
      if (s_rx) begin
        if (s_ferr) begin
          m_collecting = 1'b0;
          m_log(3'd2);
        end else begin
          m_bytes.push_back(s_data);
          if (m_bytes.size() == 4) begin
            m_collecting = 1'b0;
            if (m_bytes[3] == (m_bytes[0] ^ m_bytes[1] ^ m_bytes[2])) begin
              m_writing = 1'b1;
              m_req     = 1'b1;
              m_addr    = m_bytes[0];
              m_data    = {m_bytes[1], m_bytes[2]};
              exp_q.push_back({m_addr, m_data});
            end else begin
              m_log(3'd1);
            end
          end
        end
      end else if (m_silent == T - 1) begin
        m_collecting = 1'b0;
        m_log(3'd3);
        s_moved      = 1'b1;
      end
    end else if (s_rx) begin
      if (s_ferr) m_log(3'd2);
      else if (s_data == 8'hA5) begin
        m_collecting = 1'b1;
        m_bytes.delete();
      end
    end
    m_silent = (s_rx || s_moved) ? 0 : m_silent + 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare / write scoreboard ----------------
  bit          prev_req = 1'b0;
  logic [23:0] got_wr;

  initial begin
    forever begin
      @(negedge Clk);
      if (compare_on && !Reset) begin
        check("WrReq",    32'(bus.WrReq),    32'(m_req));
        check("Busy",     32'(bus.Busy),     32'(m_collecting || m_writing));
        check("PktCount", 32'(bus.PktCount), 32'(m_pkt));
        check("ErrCount", 32'(bus.ErrCount), 32'(m_err));
        check("LastErr",  32'(bus.LastErr),  32'(m_last));
        if (m_req) begin
          check("WrAddr", 32'(bus.WrAddr), 32'(m_addr));
          check("WrData", 32'(bus.WrData), 32'(m_data));
        end
        if (bus.WrReq && !prev_req) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(bus.WrReq), 32'(0));
          end else begin
            got_wr = exp_q.pop_front();
            check("write_addr_data", 32'({bus.WrAddr, bus.WrData}), 32'(got_wr));
          end
        end
      end
      prev_req = bus.WrReq;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr);
    bus.RxValid    = 1'b1;
    bus.RxData     = b;
    bus.RxFrameErr = ferr;
    @(negedge Clk);
    bus.RxValid    = 1'b0;
    bus.RxFrameErr = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d_hi,
                          input logic [7:0] d_lo, input logic [7:0] chk);
    send_byte(8'hA5, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d_hi, 1'b0);
    send_byte(d_lo, 1'b0);
    send_byte(chk, 1'b0);
  endtask

  task automatic pulse_ack();
    bus.WrAck = 1'b1;
    @(negedge Clk);
    bus.WrAck = 1'b0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.RxValid    = 1'b0;
    bus.RxData     = 8'h00;
    bus.RxFrameErr = 1'b0;
    bus.WrAck      = 1'b0;
    repeat (3) @(negedge Clk);
    Reset      = 1'b0;
    compare_on = 1'b1;

    check("rst_WrReq",    32'(bus.WrReq),    32'(0));
    check("rst_WrAddr",   32'(bus.WrAddr),   32'(0));
    check("rst_WrData",   32'(bus.WrData),   32'(0));
    check("rst_Busy",     32'(bus.Busy),     32'(0));
    check("rst_PktCount", 32'(bus.PktCount), 32'(0));
    check("rst_ErrCount", 32'(bus.ErrCount), 32'(0));
    check("rst_LastErr",  32'(bus.LastErr),  32'(0));
    check("rst_State",    32'(bus.DbgState), 32'(ST_IDLE));

    // Good packet, acked on the third cycle
    send_pkt(8'h12, 8'hBE, 8'hEF, 8'h43);
    check("good_WrReq",  32'(bus.WrReq),  32'(1));
    check("good_WrAddr", 32'(bus.WrAddr), 32'(8'h12));
    check("good_WrData", 32'(bus.WrData), 32'(16'hBEEF));
    idle(2);
    pulse_ack();
    check("good_done_WrReq", 32'(bus.WrReq),    32'(0));
    check("good_PktCount",   32'(bus.PktCount), 32'(1));
    check("good_ErrCount",   32'(bus.ErrCount), 32'(0));

    // Bad checksum
    send_pkt(8'h12, 8'hBE, 8'hEF, 8'h00);
    check("badchk_WrReq",    32'(bus.WrReq),    32'(0));
    check("badchk_ErrCount", 32'(bus.ErrCount), 32'(1));
    check("badchk_LastErr",  32'(bus.LastErr),  32'(1));
    check("badchk_Busy",     32'(bus.Busy),     32'(0));

    // Byte timeout after A5 12
    send_byte(8'hA5, 1'b0);
    send_byte(8'h12, 1'b0);
    idle(T - 1);
    check("tmo_still_busy", 32'(bus.Busy), 32'(1));
    idle(1);
    check("tmo_Busy",     32'(bus.Busy),     32'(0));
    check("tmo_LastErr",  32'(bus.LastErr),  32'(3));
    check("tmo_ErrCount", 32'(bus.ErrCount), 32'(2));
    send_pkt(8'h01, 8'h00, 8'h10, 8'h11);
    check("after_tmo_WrAddr", 32'(bus.WrAddr), 32'(8'h01));
    check("after_tmo_WrData", 32'(bus.WrData), 32'(16'h0010));
    pulse_ack();
    check("after_tmo_PktCount", 32'(bus.PktCount), 32'(2));

    // Byte landing on the expiry cycle is accepted
    send_byte(8'hA5, 1'b0);
    idle(T - 1);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    check("edge_WrReq",    32'(bus.WrReq),    32'(1));
    check("edge_ErrCount", 32'(bus.ErrCount), 32'(2));
    pulse_ack();
    check("edge_PktCount", 32'(bus.PktCount), 32'(3));

    // Framing error on DHI, then in IDLE; junk byte and stray ack ignored
    send_byte(8'hA5, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b1);
    check("ferr_Busy",     32'(bus.Busy),     32'(0));
    check("ferr_LastErr",  32'(bus.LastErr),  32'(2));
    check("ferr_ErrCount", 32'(bus.ErrCount), 32'(3));
    send_byte(8'h3C, 1'b1);
    check("ferr_idle_ErrCount", 32'(bus.ErrCount), 32'(4));
    send_byte(8'h77, 1'b0);
    pulse_ack();
    check("junk_ErrCount", 32'(bus.ErrCount), 32'(4));
    check("junk_PktCount", 32'(bus.PktCount), 32'(3));

    // A5 inside the packet is data
    send_pkt(8'hA5, 8'hA5, 8'hA5, 8'hA5);
    check("a5_WrAddr", 32'(bus.WrAddr), 32'(8'hA5));
    check("a5_WrData", 32'(bus.WrData), 32'(16'hA5A5));
    pulse_ack();

    // Overrun then write timeout
    send_pkt(8'h20, 8'h12, 8'h34, 8'h06);
    idle(2);
    send_byte(8'h77, 1'b0);
    check("ovr_LastErr",  32'(bus.LastErr),  32'(4));
    check("ovr_WrReq",    32'(bus.WrReq),    32'(1));
    check("ovr_ErrCount", 32'(bus.ErrCount), 32'(5));
    idle(T - 1);
    check("wtmo_pre_WrReq", 32'(bus.WrReq), 32'(1));
    idle(1);
    check("wtmo_WrReq",    32'(bus.WrReq),    32'(0));
    check("wtmo_LastErr",  32'(bus.LastErr),  32'(5));
    check("wtmo_ErrCount", 32'(bus.ErrCount), 32'(6));
    check("wtmo_PktCount", 32'(bus.PktCount), 32'(4));

    // Ack together with a byte
    send_pkt(8'h40, 8'h00, 8'h01, 8'h41);
    idle(1);
    bus.WrAck = 1'b1;
    send_byte(8'h99, 1'b0);
    bus.WrAck = 1'b0;
    check("ackrx_PktCount", 32'(bus.PktCount), 32'(5));
    check("ackrx_LastErr",  32'(bus.LastErr),  32'(4));
    check("ackrx_ErrCount", 32'(bus.ErrCount), 32'(7));

    // Ack on the expiry cycle wins
    send_pkt(8'h50, 8'h60, 8'h70, 8'h40);
    idle(T - 1);
    pulse_ack();
    check("acktmo_PktCount", 32'(bus.PktCount), 32'(6));
    check("acktmo_ErrCount", 32'(bus.ErrCount), 32'(7));

    // Reset in the middle of a write
    send_pkt(8'h66, 8'h01, 8'h02, 8'h65);
    check("prerst_WrReq", 32'(bus.WrReq), 32'(1));
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_WrReq",    32'(bus.WrReq),    32'(0));
    check("midrst_WrAddr",   32'(bus.WrAddr),   32'(0));
    check("midrst_WrData",   32'(bus.WrData),   32'(0));
    check("midrst_Busy",     32'(bus.Busy),     32'(0));
    check("midrst_PktCount", 32'(bus.PktCount), 32'(0));
    check("midrst_ErrCount", 32'(bus.ErrCount), 32'(0));
    check("midrst_LastErr",  32'(bus.LastErr),  32'(0));
    @(negedge Clk);
    Reset = 1'b0;

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_pkt(8'h00, 8'h00, 8'h00, 8'h01);
    check("sat_ErrCount", 32'(bus.ErrCount), 32'(8'hFF));
    check("sat_LastErr",  32'(bus.LastErr),  32'(1));
    send_byte(8'h00, 1'b1);
    check("sat_hold_ErrCount", 32'(bus.ErrCount), 32'(8'hFF));
    check("sat_hold_LastErr",  32'(bus.LastErr),  32'(2));
    send_pkt(8'h0F, 8'hF0, 8'h00, 8'hFF);
    pulse_ack();
    check("post_sat_PktCount", 32'(bus.PktCount), 32'(1));

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    summary();
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: actual=still running required=finished at %0t", $time);
    summary();
    $finish;
  end

endmodule
